// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions.
//   DATA_W / ADDR_W / CTRL_W / CNT_W : default widths for stage registers
//   REG_ZERO                         : hard-wired zero register address
//   CTRL_*                           : bit positions inside the control bundle
//                                      {ALUOp[2:0],ALUSrc,MemToReg,MemWrite,MemRead,RegWrite}
package pipeline_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 16;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_ALU_OP_LO  = 5;
  localparam int CTRL_ALU_OP_HI  = 7;
endpackage

// File: rtl/id_ex_bypass_mux.sv
// Operand selection for one register-file read port.
//   addr    : source register address being read
//   rf_data : register-file read data (pre-write value on a same-cycle write)
//   wb_en, wb_addr, wb_data : writeback port, same nets as the register-file write
//   operand : value EX should see for this source
// Register 0 always reads zero. Otherwise a writeback to the same address in
// this cycle wins, because the register file only commits it on the edge.
module id_ex_bypass_mux #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] operand
);
  always_comb begin
    operand = rf_data;
    if (addr == '0) begin
      operand = '0;
    end else if (wb_en && (wb_addr == addr)) begin
      // addr is non-zero here, so wb_addr is non-zero too
      operand = wb_data;
    end
  end
endmodule

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with writeback bypass, load-use hazard detection
// and bubble insertion.
//   Clock, Reset_n        : rising-edge clock, asynchronous active-low reset
//   Instr_valid, Rs_addr, Rt_addr, Dest_addr, Uses_rt, Read_data1/2, Imm, Ctrl_in
//                         : decoded instruction from ID
//   WB_Write_En/addr/data : writeback port (bypassed into the captured operands)
//   Flush                 : ID instruction is wrong-path
//   Stall_out             : combinational, IF/ID and PC hold this cycle
//   Ex_*                  : registered EX-stage view of the instruction
//   Bubble_count          : saturating count of bubbles caused by Flush or stall
// Stall protocol: Stall_out is asserted in the same cycle as the dependent
// instruction sits in ID; the edge then loads a bubble into EX and ID holds.
// Because the bubble clears Ex_valid, a stall never lasts more than one cycle.
module id_ex_stage_register #(
  parameter int DATA_W = pipeline_pkg::DATA_W,
  parameter int ADDR_W = pipeline_pkg::ADDR_W,
  parameter int CTRL_W = pipeline_pkg::CTRL_W,
  parameter int CNT_W  = pipeline_pkg::CNT_W
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Instr_valid,
  input  logic [ADDR_W-1:0] Rs_addr,
  input  logic [ADDR_W-1:0] Rt_addr,
  input  logic [ADDR_W-1:0] Dest_addr,
  input  logic              Uses_rt,
  input  logic [DATA_W-1:0] Read_data1,
  input  logic [DATA_W-1:0] Read_data2,
  input  logic [DATA_W-1:0] Imm,
  input  logic [CTRL_W-1:0] Ctrl_in,
  input  logic              WB_Write_En,
  input  logic [ADDR_W-1:0] WB_Write_addr,
  input  logic [DATA_W-1:0] WB_Write_data,
  input  logic              Flush,
  output logic              Stall_out,
  output logic              Ex_valid,
  output logic [DATA_W-1:0] Ex_rs_data,
  output logic [DATA_W-1:0] Ex_rt_data,
  output logic [DATA_W-1:0] Ex_imm,
  output logic [ADDR_W-1:0] Ex_rs_addr,
  output logic [ADDR_W-1:0] Ex_rt_addr,
  output logic [ADDR_W-1:0] Ex_dest_addr,
  output logic [CTRL_W-1:0] Ex_ctrl,
  output logic [CNT_W-1:0]  Bubble_count
);
  import pipeline_pkg::*;

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [DATA_W-1:0] rs_operand;
  logic [DATA_W-1:0] rt_operand;
  logic              hazard;
  logic              counted_bubble;
  logic              insert_bubble;

  id_ex_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs_mux (
    .addr    (Rs_addr),
    .rf_data (Read_data1),
    .wb_en   (WB_Write_En),
    .wb_addr (WB_Write_addr),
    .wb_data (WB_Write_data),
    .operand (rs_operand)
  );

  id_ex_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rt_mux (
    .addr    (Rt_addr),
    .rf_data (Read_data2),
    .wb_en   (WB_Write_En),
    .wb_addr (WB_Write_addr),
    .wb_data (WB_Write_data),
    .operand (rt_operand)
  );

  // A load in EX whose result is needed by the instruction in ID. Rt only
  // matters when the instruction actually reads it as an operand.
  always_comb begin
    hazard = Instr_valid && Ex_valid && Ex_ctrl[CTRL_MEM_READ] &&
             (Ex_dest_addr != ZERO_ADDR) &&
             ((Ex_dest_addr == Rs_addr) || (Uses_rt && (Ex_dest_addr == Rt_addr)));
  end

  // Flush overrides the stall: a wrong-path instruction must not hold the front end.
  assign Stall_out      = hazard && !Flush;
  assign counted_bubble = Flush || Stall_out;
  assign insert_bubble  = counted_bubble || !Instr_valid;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Ex_valid     <= 1'b0;
      Ex_rs_data   <= '0;
      Ex_rt_data   <= '0;
      Ex_imm       <= '0;
      Ex_rs_addr   <= '0;
      Ex_rt_addr   <= '0;
      Ex_dest_addr <= '0;
      Ex_ctrl      <= '0;
      Bubble_count <= '0;
    end else begin
      // Data and address fields load every cycle; a bubble is marked solely by
      // Ex_valid=0 and a zeroed control bundle.
      Ex_rs_data   <= rs_operand;
      Ex_rt_data   <= rt_operand;
      Ex_imm       <= Imm;
      Ex_rs_addr   <= Rs_addr;
      Ex_rt_addr   <= Rt_addr;
      Ex_dest_addr <= Dest_addr;
      if (insert_bubble) begin
        Ex_valid <= 1'b0;
        Ex_ctrl  <= '0;
      end else begin
        Ex_valid <= 1'b1;
        Ex_ctrl  <= Ctrl_in;
      end
      if (counted_bubble && (Bubble_count != CNT_MAX)) begin
        Bubble_count <= Bubble_count + CNT_ONE;
      end
    end
  end
endmodule

// File: tb/tb_id_ex_stage_register.sv
module tb_id_ex_stage_register;
  import pipeline_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 8;
  localparam int NW = 16;
  localparam int CNT_SAT = (1 << NW) - 1;

  localparam logic [CW-1:0] CTRL_LOAD = 8'b000_0_1_0_1_1; // MemToReg, MemRead, RegWrite
  localparam logic [CW-1:0] CTRL_ALU  = 8'b010_0_0_0_0_1; // ALU op, RegWrite

  // ---------------------------------------------------------------- clock/reset
  logic          Clock = 1'b0;
  logic          Reset_n;
  logic          Instr_valid;
  logic [AW-1:0] Rs_addr, Rt_addr, Dest_addr;
  logic          Uses_rt;
  logic [DW-1:0] Read_data1, Read_data2, Imm;
  logic [CW-1:0] Ctrl_in;
  logic          WB_Write_En;
  logic [AW-1:0] WB_Write_addr;
  logic [DW-1:0] WB_Write_data;
  logic          Flush;
  logic          Stall_out;
  logic          Ex_valid;
  logic [DW-1:0] Ex_rs_data, Ex_rt_data, Ex_imm;
  logic [AW-1:0] Ex_rs_addr, Ex_rt_addr, Ex_dest_addr;
  logic [CW-1:0] Ex_ctrl;
  logic [NW-1:0] Bubble_count;

  always #5 Clock = ~Clock;

  id_ex_stage_register dut (
    .Clock         (Clock),
    .Reset_n       (Reset_n),
    .Instr_valid   (Instr_valid),
    .Rs_addr       (Rs_addr),
    .Rt_addr       (Rt_addr),
    .Dest_addr     (Dest_addr),
    .Uses_rt       (Uses_rt),
    .Read_data1    (Read_data1),
    .Read_data2    (Read_data2),
    .Imm           (Imm),
    .Ctrl_in       (Ctrl_in),
    .WB_Write_En   (WB_Write_En),
    .WB_Write_addr (WB_Write_addr),
    .WB_Write_data (WB_Write_data),
    .Flush         (Flush),
    .Stall_out     (Stall_out),
    .Ex_valid      (Ex_valid),
    .Ex_rs_data    (Ex_rs_data),
    .Ex_rt_data    (Ex_rt_data),
    .Ex_imm        (Ex_imm),
    .Ex_rs_addr    (Ex_rs_addr),
    .Ex_rt_addr    (Ex_rt_addr),
    .Ex_dest_addr  (Ex_dest_addr),
    .Ex_ctrl       (Ex_ctrl),
    .Bubble_count  (Bubble_count)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_tests = 0;
  int n_fail  = 0;

  // Reference view of the EX stage: what instruction should be there, if any.
  typedef struct {
    bit            valid;
    logic [DW-1:0] rs_data, rt_data, imm;
    logic [AW-1:0] rs, rt, dest;
    logic [CW-1:0] ctrl;
  } ex_slot_t;

  ex_slot_t m_ex;
  int       m_bubbles;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_operand(input logic [AW-1:0] a, input logic [DW-1:0] rf);
    if (a == 0) return '0;
    if (WB_Write_En && WB_Write_addr == a) return WB_Write_data;
    return rf;
  endfunction

  function automatic bit ref_stall();
    bit is_load, depends;
    is_load = m_ex.valid && m_ex.ctrl[CTRL_MEM_READ] && (m_ex.dest != 0);
    depends = (m_ex.dest == Rs_addr) || (Uses_rt && (m_ex.dest == Rt_addr));
    return Instr_valid && is_load && depends && !Flush;
  endfunction

  function automatic void model_clear();
    m_ex.valid = 0; m_ex.rs_data = '0; m_ex.rt_data = '0; m_ex.imm = '0;
    m_ex.rs = '0; m_ex.rt = '0; m_ex.dest = '0; m_ex.ctrl = '0;
    m_bubbles = 0;
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic drive_idle();
    Instr_valid = 0; Rs_addr = '0; Rt_addr = '0; Dest_addr = '0; Uses_rt = 0;
    Read_data1 = '0; Read_data2 = '0; Imm = '0; Ctrl_in = '0;
    WB_Write_En = 0; WB_Write_addr = '0; WB_Write_data = '0; Flush = 0;
  endtask

  task automatic drive_instr(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                             input logic [AW-1:0] dest, input logic urt,
                             input logic [CW-1:0] ctrl);
    drive_idle();
    Instr_valid = 1; Rs_addr = rs; Rt_addr = rt; Dest_addr = dest; Uses_rt = urt;
    Ctrl_in = ctrl; Read_data1 = $urandom; Read_data2 = $urandom; Imm = $urandom;
  endtask

  task automatic drive_random();
    Instr_valid   = ($urandom_range(0, 9) < 8);
    Rs_addr       = AW'($urandom_range(0, 7));
    Rt_addr       = AW'($urandom_range(0, 7));
    Dest_addr     = AW'($urandom_range(0, 7));
    Uses_rt       = $urandom_range(0, 1);
    Read_data1    = $urandom;
    Read_data2    = $urandom;
    Imm           = $urandom;
    Ctrl_in       = ($urandom_range(0, 9) < 4) ? CTRL_LOAD : CW'($urandom);
    WB_Write_En   = $urandom_range(0, 1);
    WB_Write_addr = AW'($urandom_range(0, 7));
    WB_Write_data = $urandom;
    Flush         = ($urandom_range(0, 9) == 0);
  endtask

  // One clock cycle: entered at a falling edge with ID inputs already driven.
  task automatic cycle();
    bit stall;
    #1;
    stall = ref_stall();
    check("stall_out", Stall_out, stall);
    if (Flush || stall || !Instr_valid) begin
      m_ex.valid = 0;
      m_ex.ctrl  = '0;
    end else begin
      m_ex.valid   = 1;
      m_ex.ctrl    = Ctrl_in;
      m_ex.rs_data = ref_operand(Rs_addr, Read_data1);
      m_ex.rt_data = ref_operand(Rt_addr, Read_data2);
      m_ex.imm     = Imm;
      m_ex.rs      = Rs_addr;
      m_ex.rt      = Rt_addr;
      m_ex.dest    = Dest_addr;
    end
    if ((Flush || stall) && m_bubbles < CNT_SAT) m_bubbles++;
    @(posedge Clock);
    #1;
    check("ex_valid", Ex_valid, m_ex.valid);
    check("ex_ctrl", Ex_ctrl, m_ex.ctrl);
    check("bubble_count", Bubble_count, m_bubbles);
    if (m_ex.valid) begin
      check("ex_rs_data", Ex_rs_data, m_ex.rs_data);
      check("ex_rt_data", Ex_rt_data, m_ex.rt_data);
      check("ex_imm", Ex_imm, m_ex.imm);
      check("ex_rs_addr", Ex_rs_addr, m_ex.rs);
      check("ex_rt_addr", Ex_rt_addr, m_ex.rt);
      check("ex_dest_addr", Ex_dest_addr, m_ex.dest);
    end
    @(negedge Clock);
  endtask

  // Asserts reset mid-cycle and checks outputs clear without a clock edge.
  task automatic do_reset();
    @(negedge Clock);
    #2 Reset_n = 0;
    #1;
    check("rst_ex_valid", Ex_valid, 0);
    check("rst_ex_ctrl", Ex_ctrl, 0);
    check("rst_ex_rs_data", Ex_rs_data, 0);
    check("rst_ex_rt_data", Ex_rt_data, 0);
    check("rst_ex_imm", Ex_imm, 0);
    check("rst_ex_addrs", {Ex_rs_addr, Ex_rt_addr, Ex_dest_addr}, 0);
    check("rst_bubble_count", Bubble_count, 0);
    model_clear();
    @(negedge Clock);
    Reset_n = 1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    Reset_n = 0;
    drive_idle();
    model_clear();
    repeat (2) @(negedge Clock);
    Reset_n = 1;

    // Put some traffic in before the first mid-cycle reset.
    repeat (6) begin drive_random(); cycle(); end
    drive_idle();
    do_reset();

    // Writeback bypass on Rs and Rt, and register 0 forced to zero.
    drive_instr(5'd3, 5'd6, 5'd1, 1, CTRL_ALU);
    Read_data1 = 32'h5; WB_Write_En = 1; WB_Write_addr = 5'd3; WB_Write_data = 32'h9;
    cycle();
    check("bypass_rs", Ex_rs_data, 32'h9);
    drive_instr(5'd0, 5'd6, 5'd1, 1, CTRL_ALU);
    Read_data1 = 32'h5; WB_Write_En = 1; WB_Write_addr = 5'd0; WB_Write_data = 32'h9;
    cycle();
    check("bypass_r0", Ex_rs_data, 32'h0);
    drive_instr(5'd2, 5'd6, 5'd1, 1, CTRL_ALU);
    Read_data2 = 32'h11; WB_Write_En = 1; WB_Write_addr = 5'd6; WB_Write_data = 32'hABCD;
    cycle();
    check("bypass_rt", Ex_rt_data, 32'hABCD);
    drive_instr(5'd2, 5'd6, 5'd1, 1, CTRL_ALU);
    Read_data2 = 32'h11; WB_Write_En = 0; WB_Write_addr = 5'd6; WB_Write_data = 32'hABCD;
    cycle();
    check("no_bypass_wen0", Ex_rt_data, 32'h11);

    // Load-use on Rs: one-cycle stall, bubble counted, then capture.
    drive_idle();
    do_reset();
    drive_instr(5'd1, 5'd2, 5'd7, 0, CTRL_LOAD);
    cycle();
    drive_instr(5'd7, 5'd2, 5'd9, 1, CTRL_ALU);
    #1 check("lu_stall_hi", Stall_out, 1);
    cycle();
    check("lu_bubble_valid", Ex_valid, 0);
    check("lu_bubble_ctrl", Ex_ctrl, 0);
    check("lu_bubble_count", Bubble_count, 1);
    #1 check("lu_stall_lo", Stall_out, 0);
    cycle();
    check("lu_capture", {Ex_valid, Ex_dest_addr}, {1'b1, 5'd9});

    // Rt match is ignored when the instruction does not read Rt.
    drive_instr(5'd1, 5'd2, 5'd4, 0, CTRL_LOAD);
    cycle();
    drive_instr(5'd1, 5'd4, 5'd8, 0, CTRL_ALU);
    #1 check("uses_rt_gate", Stall_out, 0);
    cycle();
    check("uses_rt_capture", Ex_valid, 1);

    // Flush beats the stall but still counts as a bubble.
    drive_instr(5'd1, 5'd2, 5'd7, 0, CTRL_LOAD);
    cycle();
    drive_instr(5'd7, 5'd2, 5'd9, 1, CTRL_ALU);
    Flush = 1;
    #1 check("flush_no_stall", Stall_out, 0);
    cycle();
    check("flush_bubble", {Ex_valid, Ex_ctrl}, 0);
    check("flush_count", Bubble_count, 2);

    // Back-to-back loads: the consumer of the older load only sees the newer one.
    drive_instr(5'd1, 5'd2, 5'd5, 0, CTRL_LOAD);
    cycle();
    drive_instr(5'd1, 5'd2, 5'd6, 0, CTRL_LOAD);
    cycle();
    drive_instr(5'd5, 5'd2, 5'd9, 1, CTRL_ALU);
    #1 check("b2b_no_stall", Stall_out, 0);
    cycle();

    // Reset while a stall is pending drops it; next edge captures normally.
    drive_instr(5'd1, 5'd2, 5'd7, 0, CTRL_LOAD);
    cycle();
    drive_instr(5'd7, 5'd2, 5'd9, 1, CTRL_ALU);
    #1 check("pre_rst_stall", Stall_out, 1);
    #1 Reset_n = 0;
    #1 check("rst_drops_stall", Stall_out, 0);
    model_clear();
    @(negedge Clock);
    Reset_n = 1;
    cycle();
    check("post_rst_capture", Ex_valid, 1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      cycle();
    end

    // Counter saturation: 0xFFFF + 2 flush bubbles.
    drive_idle();
    do_reset();
    Flush = 1;
    repeat (CNT_SAT - 1) @(posedge Clock);
    #1 check("sat_below_max", Bubble_count, CNT_SAT - 1);
    repeat (3) @(posedge Clock);
    #1 check("sat_hold", Bubble_count, CNT_SAT);
    check("sat_valid", Ex_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound in case a wait never completes.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end
endmodule
